// File: rtl/ahb_lite_master_port_pkg.sv
// rtl/ahb_lite_master_port_pkg.sv - shared AHB-Lite encodings and helpers
package ahb_lite_master_port_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // Requester size code to HSIZE; the illegal code 3 is clamped to a word access.
    function automatic logic [2:0] size_to_hsize(input logic [1:0] size);
        logic [2:0] hsize;
        case (size)
            2'd0:    hsize = HSIZE_BYTE;
            2'd1:    hsize = HSIZE_HALF;
            default: hsize = HSIZE_WORD;
        endcase
        return hsize;
    endfunction

endpackage

// File: rtl/ahb_lite_master_port.sv
// rtl/ahb_lite_master_port.sv - valid/ready request stream to pipelined AHB-Lite SINGLE transfers
module ahb_lite_master_port
    import ahb_lite_master_port_pkg::*;
#(
    parameter int         AW        = 32,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic          req_write,
    input  logic [1:0]    req_size,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic [AW-1:0] HADDR,
    output logic [1:0]    HTRANS,
    output logic [2:0]    HSIZE,
    output logic          HWRITE,
    output logic [2:0]    HBURST,
    output logic [3:0]    HPROT,
    output logic [31:0]   HWDATA,
    input  logic [31:0]   HRDATA,
    input  logic          HREADY,
    input  logic          HRESP
);

    // Address slot: address/size/direction live directly in HADDR/HSIZE/HWRITE,
    // only the write data needs its own holding register until the data phase.
    logic        a_valid;
    logic        a_cancel;
    logic [31:0] a_wdata;

    // Data slot: what is needed to build the response when the data phase ends.
    logic        d_valid;
    logic        d_write;
    logic        d_cancel;

    // High during the second cycle of a two-cycle ERROR response.
    logic        err_cycle;

    logic        advance;
    logic        accept;
    logic        err_start;
    logic        a_valid_nxt;
    logic        a_cancel_nxt;
    logic        d_done;

    assign advance   = HREADY;
    assign req_ready = (~a_valid | HREADY) & ~err_cycle;
    assign accept    = req_valid & req_ready;

    // First cycle of an ERROR response from a live data phase.
    assign err_start = d_valid & ~d_cancel & (HRESP == HRESP_ERROR) & ~HREADY & ~err_cycle;

    // The address slot is occupied after the edge if a request lands in it or the
    // current occupant is stalled; anything in it when an error starts is cancelled.
    assign a_valid_nxt  = accept | (a_valid & ~advance);
    assign a_cancel_nxt = a_valid_nxt & (err_start | (a_cancel & ~advance));

    assign d_done = advance & d_valid;

    assign HBURST = HBURST_SINGLE;
    assign HPROT  = HPROT_VAL;

    // Pipeline slot bookkeeping and error-cancel window.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            a_valid   <= 1'b0;
            a_cancel  <= 1'b0;
            a_wdata   <= '0;
            d_valid   <= 1'b0;
            d_write   <= 1'b0;
            d_cancel  <= 1'b0;
            err_cycle <= 1'b0;
        end else begin
            a_valid  <= a_valid_nxt;
            a_cancel <= a_cancel_nxt;
            if (accept) begin
                a_wdata <= req_wdata;
            end
            if (advance) begin
                d_valid  <= a_valid;
                d_write  <= HWRITE;
                d_cancel <= a_cancel;
            end
            if (err_start) begin
                err_cycle <= 1'b1;
            end else if (advance) begin
                err_cycle <= 1'b0;
            end
        end
    end

    // Registered AHB address/control and data-phase write data.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HADDR  <= '0;
            HTRANS <= HTRANS_IDLE;
            HSIZE  <= HSIZE_BYTE;
            HWRITE <= 1'b0;
            HWDATA <= '0;
        end else begin
            HTRANS <= (a_valid_nxt && !a_cancel_nxt) ? HTRANS_NONSEQ : HTRANS_IDLE;
            if (accept) begin
                HADDR  <= req_addr;
                HSIZE  <= size_to_hsize(req_size);
                HWRITE <= req_write;
            end
            // A cancelled write never reaches the bus, so its data is not driven.
            if (advance && a_valid && HWRITE && !a_cancel) begin
                HWDATA <= a_wdata;
            end
        end
    end

    // One response per data slot leaving the pipeline, in issue order.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= d_done;
            rsp_err   <= d_done & (d_cancel | (HRESP == HRESP_ERROR));
            rsp_rdata <= (d_done && !d_write && !d_cancel) ? HRDATA : 32'h0;
        end
    end

endmodule

// File: doc/ahb_lite_master_port.md
Name: ahb_lite_master_port

Overview:
Single-initiator AHB-Lite master. It turns a simple valid/ready request stream into pipelined AHB-Lite SINGLE transfers and returns per-transfer responses in order. It is the bus-driving counterpart of the team's AHB slave peripherals (GPIO, timers, UART). Uses include a test/debug initiator, a DMA front end, or a bridge from a non-AHB block onto the system bus.

Parameters:
AW, 32, address width (HADDR and req_addr).
HPROT_VAL, 4'b0011, constant driven on HPROT (data access, privileged).

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted on the edge where req_valid&req_ready
req_addr  in  AW  byte address; requester guarantees alignment to req_size
req_write  in  1  1=write, 0=read
req_size  in  2  0=byte, 1=half, 2=word (3 illegal)
req_wdata  in  32  write data, already lane-positioned
rsp_valid  out  1  one-cycle pulse per completed or cancelled request
rsp_rdata  out  32  HRDATA captured for reads; 0 for writes
rsp_err  out  1  transfer got ERROR response or was cancelled
HADDR  out  AW  address phase
HTRANS  out  2  IDLE or NONSEQ only
HSIZE  out  3  {1'b0,req_size}
HWRITE  out  1  transfer direction
HBURST  out  3  constant SINGLE (3'b000)
HPROT  out  4  HPROT_VAL
HWDATA  out  32  data phase write data
HRDATA  in  32  read data
HREADY  in  1  transfer-complete/extend
HRESP  in  1  0=OKAY, 1=ERROR

Behaviour:
- Reset values: HTRANS=IDLE, HADDR=0, HSIZE=0, HWRITE=0, HWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. req_ready is combinational and reads 1 after reset.
- All AHB outputs come from registers. The block holds two pipeline slots: an address slot (A) and a data slot (D).
- Acceptance: req_ready = (A empty or HREADY) and not in error-cancel cycle. On accept, A loads on the edge, and HTRANS=NONSEQ from the next cycle.
- Advance, at an edge with HREADY=1:
  - A moves to D. HWDATA gets A's wdata for the data phase.
  - D completes: rsp_valid=1 in the following cycle.
  - Reads: rsp_rdata=HRDATA sampled at that edge, rsp_err=HRESP.
- HREADY=0: A, D, HADDR, HTRANS, HSIZE, HWRITE and HWDATA hold stable (AHB rule).
- Latency with zero wait states: accept at edge E0, address phase cycle 1, data phase cycle 2, rsp_valid in cycle 3. Throughput is one transfer per cycle.
- When A is empty after advancing, HTRANS=IDLE. HADDR holds its last value.
- Two-cycle ERROR: an edge with HRESP=1, HREADY=0 starts the error-cancel cycle.
  - If A is occupied, HTRANS is driven IDLE for the next cycle, and the A request is marked cancelled.
  - req_ready=0 during that cycle.
  - At the completing edge (HRESP=1, HREADY=1), D responds with rsp_err=1.
  - The cancelled A entry responds with rsp_err=1, rsp_rdata=0 in the next cycle, never re-issued. Responses stay in request order.
- An ERROR on the final cycle without a preceding HREADY=0 cycle is a protocol violation. The block still completes with rsp_err=1.
- Simultaneous events: accept and advance on the same edge is legal (the pipeline refills).
- req_size=3 is a requester error: HSIZE is forced to word.
- Reset mid-transfer: asynchronous clear. In-flight requests are dropped with no response, and HTRANS=IDLE immediately.
- No response back-pressure: the consumer must take rsp_valid every cycle.

Decomposition:
- Shared AHB header holds the constants: HTRANS_IDLE=2'b00, HTRANS_NONSEQ=2'b10, HSIZE_BYTE/HALF/WORD, HRESP_OKAY/ERROR, HBURST_SINGLE. Slaves use the same header.
- Single module, no sub-module; the two pipeline slots are too small to split.

Test Plan:
- Write 0x4000_0000 data 0xA5A5_5A5A, HREADY=1: HTRANS=NONSEQ one cycle; HWDATA=0xA5A5_5A5A next cycle; rsp_valid with rsp_err=0 three cycles after accept.
- Read 0x4000_0004 with slave inserting 2 wait states then HRDATA=0x1234_5678: address, control and HWDATA stable through the waits; rsp_rdata=0x1234_5678, rsp_err=0.
- Three back-to-back word writes to 0x0, 0x4, 0x8 with req_valid held: HTRANS=NONSEQ three consecutive cycles; three consecutive rsp_valid pulses, in order.
- Read then write pending, slave errors the read (HRESP=1/HREADY=0, then HRESP=1/HREADY=1): HTRANS goes IDLE in the second cycle; read responds rsp_err=1, then the write responds rsp_err=1; no bus write occurs.
- Byte write size=0 to 0x4000_0003 with lane data 0xEF00_0000: HSIZE=3'b000, HADDR=0x4000_0003, HWDATA=0xEF00_0000.
- Assert HRESETn low during a data phase with HREADY=0: outputs return to reset values asynchronously; no rsp_valid follows; after release, a new request completes normally.
